// File: rtl/wm_pkg.sv
// Shared washing-machine definitions.
// Holds the state codes seen by both the controller and the external phase
// timer, plus the dwell-counter width and a helper that says which states
// are timed (and therefore watched for a stuck phase).
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHECK_DOOR = 3'd1,
        FILL_WATER = 3'd2,
        HEAT_WATER = 3'd3,
        WASH       = 3'd4,
        RINSE      = 3'd5,
        SPIN       = 3'd6,
        COMPLETE   = 3'd7
    } state_t;

    localparam int                 DWELL_W   = 8;
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    // States 2..6 are driven by timer flags and can stall.
    function automatic logic is_timed(state_t s);
        return (s inside {FILL_WATER, HEAT_WATER, WASH, RINSE, SPIN});
    endfunction

endpackage

// File: rtl/wash_controller_if.sv
// Controller <-> machine signal bundle.
// slave  : the controller (samples commands/sensors/timer flags, drives
//          the state code, actuators and status).
// master : the environment (machine, timer, user panel, or a bench).
interface wash_controller_if;

    logic       start;
    logic       cancel;
    logic       door_Closed;
    logic       sig_Full;
    logic       sig_Temperature;
    logic       sig_Completed;
    logic [2:0] state;
    logic       water_Inlet;
    logic       heater_On;
    logic       motor_On;
    logic       door_Lock;
    logic       done;
    logic       fault;

    modport slave (
        input  start, cancel, door_Closed, sig_Full, sig_Temperature, sig_Completed,
        output state, water_Inlet, heater_On, motor_On, door_Lock, done, fault
    );

    modport master (
        output start, cancel, door_Closed, sig_Full, sig_Temperature, sig_Completed,
        input  state, water_Inlet, heater_On, motor_On, door_Lock, done, fault
    );

endinterface

// File: rtl/wm_watchdog.sv
// Dwell-time watchdog for the timed states.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : state is changing this cycle, restart the count
//   timed          : current state is one of the timed states
//   timeout        : dwell count has reached TIMEOUT_CYCLES-1 in a timed state
module wm_watchdog
    import wm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic timed,
    output logic timeout
);

    localparam logic [DWELL_W-1:0] LIMIT = DWELL_W'(TIMEOUT_CYCLES - 1);

    logic [DWELL_W-1:0] dwell;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dwell <= '0;
        end else if (clear) begin
            dwell <= '0;
        end else if (timed && dwell != DWELL_MAX) begin
            dwell <= dwell + 1'b1;
        end
    end

    // Registered count only, so no loop through the next-state logic.
    assign timeout = timed && (dwell == LIMIT);

endmodule

// File: rtl/wash_controller.sv
// Washing-machine sequence controller.
// Ports:
//   clock, reset_n : sole clock, asynchronous active-low reset
//   bus (slave)    : start/cancel/door_Closed and the timer flags in;
//                    state code, actuators, done and sticky fault out.
// Sequence: IDLE -> CHECK_DOOR -> FILL -> HEAT -> WASH, then RINSE_PASSES
// rounds of FILL -> RINSE, then SPIN -> COMPLETE. All outputs are registered.
module wash_controller
    import wm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int RINSE_PASSES   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    wash_controller_if.slave  bus
);

    localparam logic [2:0] PASSES = 3'(RINSE_PASSES);

    state_t     state_q, state_d;
    logic       entry_q;            // first cycle in the current state
    logic       rinse_q, rinse_d;   // past WASH: fills now lead to RINSE
    logic [1:0] pass_q, pass_d;
    logic       fault_q, fault_d;
    logic       flag;
    logic       timeout;
    logic       water_q, heater_q, motor_q, lock_q, done_q;

    wm_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .timed   (is_timed(state_q)),
        .timeout (timeout)
    );

    // Exit flag of the current state. Timer flags lag a cycle and
    // sig_Completed is shared, so the entry cycle never sees a flag.
    always_comb begin
        flag = 1'b0;
        case (state_q)
            FILL_WATER:        flag = bus.sig_Full;
            HEAT_WATER:        flag = bus.sig_Temperature;
            WASH, RINSE, SPIN: flag = bus.sig_Completed;
            default:           flag = 1'b0;
        endcase
        if (entry_q) flag = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        rinse_d = rinse_q;
        pass_d  = pass_q;
        fault_d = fault_q;
        case (state_q)
            IDLE:       if (bus.start && !bus.cancel) begin
                            state_d = CHECK_DOOR;
                            fault_d = 1'b0;
                        end
            CHECK_DOOR: if (bus.door_Closed) state_d = FILL_WATER;
            FILL_WATER: if (flag) state_d = rinse_q ? RINSE : HEAT_WATER;
            HEAT_WATER: if (flag) state_d = WASH;
            WASH:       if (flag) begin
                            state_d = FILL_WATER;
                            rinse_d = 1'b1;
                        end
            RINSE:      if (flag) begin
                            pass_d  = 2'(pass_q + 2'd1);
                            state_d = (({1'b0, pass_q} + 3'd1) >= PASSES) ? SPIN : FILL_WATER;
                        end
            SPIN:       if (flag) state_d = COMPLETE;
            COMPLETE:   if (!bus.door_Closed) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        // A flag arriving on the timeout cycle wins: normal exit, no fault.
        if (timeout && !flag && !bus.cancel) begin
            state_d = IDLE;
            fault_d = 1'b1;
        end
        if (bus.cancel && state_q != IDLE) state_d = IDLE;
        if (state_d == WASH && state_q != WASH) pass_d = 2'd0;
        if (state_d == IDLE) rinse_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            entry_q  <= 1'b0;
            rinse_q  <= 1'b0;
            pass_q   <= 2'd0;
            fault_q  <= 1'b0;
            water_q  <= 1'b0;
            heater_q <= 1'b0;
            motor_q  <= 1'b0;
            lock_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= (state_d != state_q);
            rinse_q  <= rinse_d;
            pass_q   <= pass_d;
            fault_q  <= fault_d;
            water_q  <= (state_d == FILL_WATER);
            heater_q <= (state_d == HEAT_WATER);
            motor_q  <= (state_d inside {WASH, RINSE, SPIN});
            lock_q   <= is_timed(state_d);
            done_q   <= (state_d == COMPLETE);
        end
    end

    assign bus.state       = state_q;
    assign bus.water_Inlet = water_q;
    assign bus.heater_On   = heater_q;
    assign bus.motor_On    = motor_q;
    assign bus.door_Lock   = lock_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_wash_controller.sv
// Bench for wash_controller: directed scenarios, a cycle-level model of the
// wash program, a per-cycle compare at negedge, and literal spot checks.
module tb_wash_controller;

    localparam int TMO = 20;
    localparam int RP  = 2;

    logic clock;
    logic reset_n;
    wash_controller_if bus();

    wash_controller #(.TIMEOUT_CYCLES(TMO), .RINSE_PASSES(RP)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    bit rec      = 0;
    int last_seen;
    int seen[$];
    int exp_seq[12] = '{0, 1, 2, 3, 4, 2, 5, 2, 5, 6, 7, 0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // {water, heater, motor, lock, done, fault}
    function automatic int dut_outs();
        return int'({bus.water_Inlet, bus.heater_On, bus.motor_On,
                     bus.door_Lock, bus.done, bus.fault});
    endfunction

    function automatic int exp_outs(int s, bit f);
        logic [4:0] a;
        case (s)
            2:       a = 5'b10010;
            3:       a = 5'b01010;
            4, 5, 6: a = 5'b00110;
            7:       a = 5'b00001;
            default: a = 5'b00000;
        endcase
        return int'({a, f});
    endfunction

    // ---- program model: state number, cycles spent in it, rinse bookkeeping
    int m_state, m_age, m_pass;
    bit m_rinse, m_fault;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_age = 0; m_pass = 0; m_rinse = 0; m_fault = 0;
        end else begin
            int ns;
            bit flg, tmo;
            ns  = m_state;
            flg = 0;
            if (m_age > 0) begin
                case (m_state)
                    2:       flg = bus.sig_Full;
                    3:       flg = bus.sig_Temperature;
                    4, 5, 6: flg = bus.sig_Completed;
                    default: flg = 0;
                endcase
            end
            tmo = (m_state >= 2 && m_state <= 6) && (m_age == TMO - 1);
            case (m_state)
                0: if (bus.start && !bus.cancel) begin ns = 1; m_fault = 0; end
                1: if (bus.door_Closed) ns = 2;
                2: if (flg) ns = m_rinse ? 5 : 3;
                3: if (flg) ns = 4;
                4: if (flg) begin ns = 2; m_rinse = 1; end
                5: if (flg) begin m_pass++; ns = (m_pass >= RP) ? 6 : 2; end
                6: if (flg) ns = 7;
                default: if (!bus.door_Closed) ns = 0;
            endcase
            if (tmo && !flg && !bus.cancel) begin ns = 0; m_fault = 1; end
            if (bus.cancel && m_state != 0) ns = 0;
            if (ns == 4) m_pass = 0;
            if (ns == 0) m_rinse = 0;
            m_age   = (ns != m_state) ? 0 : m_age + 1;
            m_state = ns;
        end
    end

    // ---- per-cycle compare
    always @(negedge clock) begin
        if (chk_en) begin
            check("state", int'(bus.state), m_state);
            check("outputs", dut_outs(), exp_outs(m_state, m_fault));
            if (rec && int'(bus.state) != last_seen) begin
                seen.push_back(int'(bus.state));
                last_seen = int'(bus.state);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_flag(int f, logic v);
        case (f)
            0:       bus.sig_Full        = v;
            1:       bus.sig_Temperature = v;
            default: bus.sig_Completed   = v;
        endcase
    endtask

    // Flag raised three cycles after entry, one cycle wide.
    task automatic phase(int f);
        repeat (3) tick();
        set_flag(f, 1'b1);
        tick();
        set_flag(f, 1'b0);
    endtask

    task automatic begin_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic do_cancel();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.cancel = 0; bus.door_Closed = 0;
        bus.sig_Full = 0; bus.sig_Temperature = 0; bus.sig_Completed = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk_en = 1;
        tick();
        check("reset_state", int'(bus.state), 0);
        check("reset_outs", dut_outs(), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // normal cycle
        last_seen = -1;
        rec = 1;
        bus.door_Closed = 1'b1;
        begin_run();
        check("normal_fill", int'(bus.state), 2);
        check("normal_fill_outs", dut_outs(), 6'b100100);
        phase(0); phase(1); phase(2); phase(0); phase(2); phase(0); phase(2); phase(2);
        check("normal_complete", int'(bus.state), 7);
        check("normal_done", int'(bus.done), 1);
        bus.start = 1'b1;
        repeat (3) tick();
        check("start_in_complete", int'(bus.state), 7);
        bus.start = 1'b0;
        bus.door_Closed = 1'b0;
        tick();
        check("complete_exit", int'(bus.state), 0);
        tick();
        rec = 0;
        check("seq_len", seen.size(), 12);
        for (int i = 0; i < 12 && i < seen.size(); i++)
            check("seq_elem", seen[i], exp_seq[i]);

        // door open
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("door_hold", int'(bus.state), 1);
            check("door_unlocked", int'(bus.door_Lock), 0);
            tick();
        end
        bus.start = 1'b0;
        bus.door_Closed = 1'b1;
        tick();
        check("door_closed_fill", int'(bus.state), 2);
        do_cancel();

        // stale sig_Completed across RINSE entry
        begin_run();
        phase(0); phase(1);
        repeat (3) tick();
        bus.sig_Completed = 1'b1;
        tick();
        check("stale_wash_exit", int'(bus.state), 2);
        tick(); tick();
        bus.sig_Full = 1'b1;
        tick();
        bus.sig_Full = 1'b0;
        check("stale_rinse_entry", int'(bus.state), 5);
        tick();
        check("stale_rinse_hold", int'(bus.state), 5);
        tick();
        check("stale_rinse_exit", int'(bus.state), 2);
        bus.sig_Completed = 1'b0;
        do_cancel();
        check("stale_cancel", int'(bus.state), 0);

        // timeout in HEAT_WATER
        begin_run();
        phase(0);
        repeat (19) tick();
        check("pre_timeout", int'(bus.state), 3);
        tick();
        check("timeout_state", int'(bus.state), 0);
        check("timeout_fault", int'(bus.fault), 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_state", int'(bus.state), 1);
        check("restart_fault", int'(bus.fault), 0);
        do_cancel();

        // cancel in WASH
        begin_run();
        phase(0); phase(1);
        tick();
        do_cancel();
        check("cancel_state", int'(bus.state), 0);
        check("cancel_motor", int'(bus.motor_On), 0);

        // asynchronous reset in SPIN
        begin_run();
        phase(0); phase(1); phase(2); phase(0); phase(2); phase(0); phase(2);
        check("spin_state", int'(bus.state), 6);
        check("spin_motor", int'(bus.motor_On), 1);
        tick();
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_state", int'(bus.state), 0);
        check("async_reset_outs", dut_outs(), 0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
